// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state/lane helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  localparam int unsigned CNT_W = 4;

  // Little-endian byte-lane enables for a transfer of the given size and offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << off;
      SIZE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Flop-based word memory: byte-enabled synchronous write, combinational read.
module ahb_slave_ram
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: address-phase decode, wait states, two-cycle ERROR.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk_ahb,
  input  logic        i_rst_ahb,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int unsigned BA_W = ADDR_W + 2;

  slv_state_e       state_q, state_d;
  logic [BA_W-1:0]  addr_q, addr_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             err_c;
  logic             pipe_ok_c;
  logic [3:0]       be_c;
  logic [31:0]      rdata_c;

  assign accept_c  = HSEL & HREADY & ((HTRANS == TRANS_NONSEQ) | (HTRANS == TRANS_SEQ));
  assign pipe_ok_c = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);

  // Illegal size, misalignment, or any address bit beyond the memory span.
  assign err_c = (HSIZE > SIZE_WORD)
               | ((HSIZE == SIZE_HALF) & HADDR[0])
               | ((HSIZE == SIZE_WORD) & (|HADDR[1:0]))
               | (|(HADDR >> BA_W));

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // A new address phase is only seen while HREADYOUT is high.
    if (accept_c && pipe_ok_c) begin
      addr_d  = HADDR[BA_W-1:0];
      write_d = HWRITE;
      size_d  = HSIZE;
      if (err_c) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(WAIT_STATES - 1);
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    HRDATA    = '0;
    be_c      = '0;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
      end
      ST_ERR2: HRESP = RESP_ERROR;
      ST_DATA: begin
        if (write_q) be_c   = lane_mask(size_q, addr_q[1:0]);
        else         HRDATA = rdata_c;
      end
      default: ;
    endcase
  end

  ahb_slave_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (i_clk_ahb),
    .rst_i   (i_rst_ahb),
    .addr_i  (addr_q[BA_W-1:2]),
    .be_i    (be_c),
    .wdata_i (HWDATA),
    .rdata_o (rdata_c)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven by directed AHB sequences.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [1:0]  htrans [2];
  logic [31:0] hwdata [2];

  logic        hrdy0, hrdy1;
  logic        hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   dp   [2];
  int   wcnt [2];

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .i_clk_ahb(clk), .i_rst_ahb(rst), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
    .HREADY(hrdy0), .HREADYOUT(hrdy0), .HRDATA(hrdata0), .HRESP(hresp0)
  );

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(3)) u_dut1 (
    .i_clk_ahb(clk), .i_rst_ahb(rst), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
    .HREADY(hrdy1), .HREADYOUT(hrdy1), .HRDATA(hrdata1), .HRESP(hresp1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Per-instance monitor step, evaluated mid-cycle.
  task automatic mon(input int i, input logic rdy, input logic resp, input logic [31:0] rdata);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rst) begin
      dp[i] = 1'b0;
      return;
    end
    if (i == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (i == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (dp[i]) begin
      if (!rdy) begin
        wcnt[i]++;
        if (have) check($sformatf("inst%0d resp_low", i), 32'(resp), 32'(e.resp));
      end else begin
        dp[i] = 1'b0;
        if (!have) begin
          n_vec++;
          n_err++;
          $display("FAIL inst%0d unexpected completion @%0t: resp %0b rdata 0x%08h", i, $time, resp, rdata);
        end else begin
          if (i == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          check($sformatf("inst%0d resp", i), 32'(resp), 32'(e.resp));
          check($sformatf("inst%0d rdata", i), rdata, e.rdata);
          check($sformatf("inst%0d waits", i), 32'(wcnt[i]), 32'(e.waits));
        end
      end
    end else begin
      check($sformatf("inst%0d idle_ready", i), 32'(rdy), 32'd1);
      check($sformatf("inst%0d idle_resp", i), 32'(resp), 32'd0);
      check($sformatf("inst%0d idle_rdata", i), rdata, 32'd0);
    end
    if (hsel[i] && rdy && htrans[i][1]) begin
      dp[i]   = 1'b1;
      wcnt[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, hrdy0, hresp0, hrdata0);
    mon(1, hrdy1, hresp1, hrdata1);
  end

  // Present one address phase (plus the previous transfer's write data) until it is taken.
  task automatic drive(input int i, input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic rdy;
    int   n;
    n = 0;
    hsel[i] = sel; htrans[i] = tr; hwrite[i] = wr;
    hsize[i] = sz; haddr[i] = a; hwdata[i] = wd;
    do begin
      @(negedge clk);
      rdy = (i == 0) ? hrdy0 : hrdy1;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL inst%0d timeout: HREADYOUT stuck low", i);
    end
  endtask

  task automatic op(input int i, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] wd_prev, input logic resp, input logic [31:0] rd, input int w);
    exp_t e;
    e.resp = resp; e.rdata = rd; e.waits = w;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(i, 1'b1, TRANS_NONSEQ, wr, sz, a, wd_prev);
  endtask

  task automatic idle(input int i, input logic [31:0] wd_prev);
    drive(i, 1'b0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, wd_prev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      hsel[i] = 1'b0; htrans[i] = TRANS_IDLE; hwrite[i] = 1'b0;
      hsize[i] = SIZE_WORD; haddr[i] = '0; hwdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait instance: pipelined writes/reads, lanes, errors, ignored cycles.
    op(0, 1'b1, SIZE_WORD, 32'h10, 32'h0,          1'b0, 32'h0,        0);
    op(0, 1'b0, SIZE_WORD, 32'h10, 32'hDEADBEEF,   1'b0, 32'hDEADBEEF, 0);
    op(0, 1'b1, SIZE_WORD, 32'h10, 32'h0,          1'b0, 32'h0,        0);
    op(0, 1'b1, SIZE_BYTE, 32'h11, 32'h11223344,   1'b0, 32'h0,        0);
    op(0, 1'b0, SIZE_WORD, 32'h10, 32'h5555AA55,   1'b0, 32'h1122AA44, 0);
    op(0, 1'b1, SIZE_HALF, 32'h12, 32'h0,          1'b0, 32'h0,        0);
    op(0, 1'b0, SIZE_WORD, 32'h10, 32'hBEEF1234,   1'b0, 32'hBEEFAA44, 0);
    op(0, 1'b1, SIZE_WORD, 32'h02, 32'h0,          1'b1, 32'h0,        1);
    op(0, 1'b1, SIZE_WORD, 32'h400, 32'hFFFFFFFF,  1'b1, 32'h0,        1);
    op(0, 1'b1, 3'd3,      32'h10, 32'hFFFFFFFF,   1'b1, 32'h0,        1);
    op(0, 1'b1, SIZE_HALF, 32'h13, 32'hFFFFFFFF,   1'b1, 32'h0,        1);
    op(0, 1'b0, SIZE_WORD, 32'h00, 32'hFFFFFFFF,   1'b0, 32'h0,        0);
    op(0, 1'b0, SIZE_WORD, 32'h10, 32'h0,          1'b0, 32'hBEEFAA44, 0);
    drive(0, 1'b1, TRANS_BUSY,   1'b1, SIZE_WORD, 32'h20, 32'h0);
    drive(0, 1'b0, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h24, 32'hA5A5A5A5);
    drive(0, 1'b1, TRANS_IDLE,   1'b1, SIZE_WORD, 32'h20, 32'h5A5A5A5A);
    op(0, 1'b0, SIZE_WORD, 32'h20, 32'h0,          1'b0, 32'h0,        0);
    op(0, 1'b0, SIZE_WORD, 32'h24, 32'h0,          1'b0, 32'h0,        0);
    idle(0, 32'h0);

    // Three-wait instance: latency, pipelined accept in the data cycle, error.
    op(1, 1'b0, SIZE_WORD, 32'h00, 32'h0,          1'b0, 32'h0,        3);
    op(1, 1'b1, SIZE_WORD, 32'h04, 32'h0,          1'b0, 32'h0,        3);
    op(1, 1'b0, SIZE_WORD, 32'h04, 32'h12345678,   1'b0, 32'h12345678, 3);
    op(1, 1'b0, SIZE_HALF, 32'h05, 32'h0,          1'b1, 32'h0,        1);
    idle(1, 32'h0);

    // Reset lands while a write sits in its wait states; the write must vanish.
    drive(1, 1'b1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h20, 32'h0);
    hsel[1] = 1'b0; htrans[1] = TRANS_IDLE; hwdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("inst1 post_reset_ready", 32'(hrdy1), 32'd1);
    check("inst1 post_reset_resp", 32'(hresp1), 32'd0);
    @(posedge clk);
    #1;
    op(1, 1'b0, SIZE_WORD, 32'h20, 32'h0,          1'b0, 32'h0,        3);
    idle(1, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("inst0 queue_drained", 32'(q0.size()), 32'd0);
    check("inst1 queue_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
